vlsu_meta_buf: RTL

Circular metadata queue on the shuffle side of the VLSU. It sits directly downstream of the meta-info broadcast stage's shuffle output and buffers one `meta_glb_t` entry per vector memory request. It exposes the oldest entry to the shuffle datapath together with a per-beat index. It retires that entry after the datapath has consumed the entry's number of data beats.

---
 rtl/vlsu_meta_buf.sv | 112 +++++++++++
 1 files changed

// File: rtl/vlsu_meta_buf.sv
// Circular metadata queue feeding the VLSU shuffle datapath: holds one entry per request and walks its data beats.
// Optional same-cycle head bypass into an empty buffer is enabled by defining VLSU_META_BUF_BYPASS_EN.
module vlsu_meta_buf #(
  parameter type         meta_glb_t = logic,
  parameter int unsigned Depth      = 4,
  parameter int unsigned BeatW      = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       meta_valid_i,
  output logic                       meta_ready_o,
  input  meta_glb_t                  meta_i,
  input  logic [BeatW-1:0]           meta_beats_i,
  output logic                       head_valid_o,
  output meta_glb_t                  head_o,
  output logic [BeatW-1:0]           beat_idx_o,
  output logic                       last_beat_o,
  input  logic                       beat_done_i,
  input  logic                       flush_i,
  output logic [$clog2(Depth+1)-1:0] usage_o,
  output logic                       empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth+1);

  meta_glb_t        meta_mem  [Depth];
  logic [BeatW-1:0] beats_mem [Depth];

  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic [BeatW-1:0] beat_q;

  logic [BeatW-1:0] beats_in;
  logic [BeatW-1:0] head_beats;
  logic             stored_valid;
  logic             enq;
  logic             bypass;
  logic             wr_en;
  logic             retire;
  logic             advance;

  // A zero beat count still occupies one beat of the datapath.
  assign beats_in     = (meta_beats_i == '0) ? BeatW'(1) : meta_beats_i;
  assign stored_valid = (count_q != '0);
  assign meta_ready_o = (count_q != CntW'(Depth)) && !flush_i;
  assign enq          = meta_valid_i && meta_ready_o;
  assign head_beats   = beats_mem[rptr_q];

  always_comb begin
    head_valid_o = stored_valid;
    head_o       = meta_mem[rptr_q];
    beat_idx_o   = beat_q;
    last_beat_o  = stored_valid && (beat_q == head_beats - BeatW'(1));
    bypass       = 1'b0;
`ifdef VLSU_META_BUF_BYPASS_EN
    // Empty buffer: present the incoming entry as head in the same cycle.
    if (!stored_valid && enq) begin
      bypass       = 1'b1;
      head_valid_o = 1'b1;
      head_o       = meta_i;
      beat_idx_o   = '0;
      last_beat_o  = (beats_in == BeatW'(1));
    end
`endif
  end

  // A bypassed single-beat entry consumed on arrival never touches storage.
  assign wr_en   = enq && !(bypass && beat_done_i && last_beat_o);
  assign retire  = beat_done_i && stored_valid && last_beat_o;
  assign advance = beat_done_i && head_valid_o && !last_beat_o;

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      meta_mem[wptr_q]  <= meta_i;
      beats_mem[wptr_q] <= beats_in;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      beat_q  <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      beat_q  <= '0;
    end else begin
      if (wr_en) begin
        wptr_q <= wptr_q + PtrW'(1);
      end
      if (retire) begin
        rptr_q <= rptr_q + PtrW'(1);
        beat_q <= '0;
      end else if (advance) begin
        beat_q <= beat_q + BeatW'(1);
      end
      case ({wr_en, retire})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign usage_o = count_q;
  assign empty_o = (count_q == '0);

endmodule
